// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

  // Frame receiver states: start bit, 8 data bits, parity bit, stop bit.
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam int         FRAME_BITS = 11;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Scan code set 2 to ASCII lookup: lowercase letters, digits and space.
// Anything not listed maps to 0x00.
module ps2_scan2ascii (
  input  logic [7:0] scan_code,
  output logic [7:0] ascii
);

  // Pure combinational ROM; the tracker registers the result.
  always_comb begin
    ascii = 8'h00;
    case (scan_code)
      8'h1C: ascii = 8'h61; // a
      8'h32: ascii = 8'h62; // b
      8'h21: ascii = 8'h63; // c
      8'h23: ascii = 8'h64; // d
      8'h24: ascii = 8'h65; // e
      8'h2B: ascii = 8'h66; // f
      8'h34: ascii = 8'h67; // g
      8'h33: ascii = 8'h68; // h
      8'h43: ascii = 8'h69; // i
      8'h3B: ascii = 8'h6A; // j
      8'h42: ascii = 8'h6B; // k
      8'h4B: ascii = 8'h6C; // l
      8'h3A: ascii = 8'h6D; // m
      8'h31: ascii = 8'h6E; // n
      8'h44: ascii = 8'h6F; // o
      8'h4D: ascii = 8'h70; // p
      8'h15: ascii = 8'h71; // q
      8'h2D: ascii = 8'h72; // r
      8'h1B: ascii = 8'h73; // s
      8'h2C: ascii = 8'h74; // t
      8'h3C: ascii = 8'h75; // u
      8'h2A: ascii = 8'h76; // v
      8'h1D: ascii = 8'h77; // w
      8'h22: ascii = 8'h78; // x
      8'h35: ascii = 8'h79; // y
      8'h1A: ascii = 8'h7A; // z
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31; // 1
      8'h1E: ascii = 8'h32; // 2
      8'h26: ascii = 8'h33; // 3
      8'h25: ascii = 8'h34; // 4
      8'h2E: ascii = 8'h35; // 5
      8'h36: ascii = 8'h36; // 6
      8'h3D: ascii = 8'h37; // 7
      8'h3E: ascii = 8'h38; // 8
      8'h46: ascii = 8'h39; // 9
      8'h29: ascii = 8'h20; // space
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: synchronizes the raw lines, deframes 11-bit
// device-to-host frames and tracks the currently held key, its ASCII
// translation and a count of new presses.
//
// Internal byte handshake: byte_valid_q is a single-cycle strobe qualifying
// byte_q; there is no back-pressure, the interpreter consumes every strobe
// in the cycle it appears. frame_err_q is a single-cycle strobe that is
// never asserted together with byte_valid_q.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       key_data,
  output logic [7:0]       key_ascii,
  output logic [CNT_W-1:0] key_count,
  output logic             key_down,
  output logic             key_ext,
  output logic             frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Line synchronizers and falling-edge detect
  // ---------------------------------------------------------------------
  logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
  logic ps2_data_meta_q, ps2_data_sync_q;
  logic fall_edge;
  logic bit_in;

  // Two-flop synchronizers plus a history flop for edge detection. Reset
  // to 0 so the idle-high line after reset shows a rise, never a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_meta_q  <= 1'b0;
      ps2_clk_sync_q  <= 1'b0;
      ps2_clk_prev_q  <= 1'b0;
      ps2_data_meta_q <= 1'b0;
      ps2_data_sync_q <= 1'b0;
    end else begin
      ps2_clk_meta_q  <= ps2_clk;
      ps2_clk_sync_q  <= ps2_clk_meta_q;
      ps2_clk_prev_q  <= ps2_clk_sync_q;
      ps2_data_meta_q <= ps2_data;
      ps2_data_sync_q <= ps2_data_meta_q;
    end
  end

  assign fall_edge = ps2_clk_prev_q & ~ps2_clk_sync_q;
  assign bit_in    = ps2_data_sync_q;

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_ok_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      tmo_cnt_q    <= tmo_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state: step one bit per ps2_clk falling edge; abandon a frame
  // whose clock stalls for TIMEOUT_CYCLES.
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (rx_state_q == RX_IDLE || fall_edge) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    if (rx_state_q != RX_IDLE && !fall_edge && tmo_cnt_q == TMO_LAST) begin
      rx_state_d  = RX_IDLE;
      frame_err_d = 1'b1;
      tmo_cnt_d   = '0;
    end else if (fall_edge) begin
      case (rx_state_q)
        RX_IDLE: begin
          // A high level on an edge is not a start bit; stay put.
          if (!bit_in) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = RX_PARITY;
          end
        end
        RX_PARITY: begin
          // Odd parity over data plus parity bit.
          par_ok_d   = ^{shift_q, bit_in};
          rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          if (bit_in && par_ok_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Scan-code interpreter
  // ---------------------------------------------------------------------
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic [7:0]       key_data_q, key_data_d;
  logic [7:0]       key_ascii_q, key_ascii_d;
  logic [CNT_W-1:0] key_count_q, key_count_d;
  logic             key_down_q, key_down_d;
  logic             key_ext_q, key_ext_d;
  logic [7:0]       rom_ascii;
  logic             held_match;

  ps2_scan2ascii u_scan2ascii (
    .scan_code (byte_q),
    .ascii     (rom_ascii)
  );

  assign held_match = key_down_q && (ext_q == key_ext_q) && (byte_q == key_data_q);

  // Interpreter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_data_q  <= 8'h00;
      key_ascii_q <= 8'h00;
      key_count_q <= '0;
      key_down_q  <= 1'b0;
      key_ext_q   <= 1'b0;
    end else begin
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_data_q  <= key_data_d;
      key_ascii_q <= key_ascii_d;
      key_count_q <= key_count_d;
      key_down_q  <= key_down_d;
      key_ext_q   <= key_ext_d;
    end
  end

  // Apply prefixes, make and break codes; key_data and key_ascii always
  // change together so the display never sees a mixed pair.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_data_d  = key_data_q;
    key_ascii_d = key_ascii_q;
    key_count_d = key_count_q;
    key_down_d  = key_down_q;
    key_ext_d   = key_ext_q;

    if (byte_valid_q) begin
      if (byte_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        if (!brk_q) begin
          // A make of the already-held key is typematic repeat.
          if (!held_match) begin
            key_data_d  = byte_q;
            key_ext_d   = ext_q;
            key_down_d  = 1'b1;
            key_ascii_d = ext_q ? 8'h00 : rom_ascii;
            key_count_d = key_count_q + 1'b1;
          end
        end else if (held_match) begin
          key_data_d  = 8'h00;
          key_ascii_d = 8'h00;
          key_ext_d   = 1'b0;
          key_down_d  = 1'b0;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  assign key_data  = key_data_q;
  assign key_ascii = key_ascii_q;
  assign key_count = key_count_q;
  assign key_down  = key_down_q;
  assign key_ext   = key_ext_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: drives bit-level PS/2 frames, keeps a
// key-state reference model and scoreboards every output change and
// every frame_err pulse.
module tb_ps2_key_tracker;

  localparam int HALF  = 10;   // ps2_clk half period in clk cycles
  localparam int TMO   = 200;
  localparam int CNT_W = 8;
  localparam int SW    = 8 + 8 + CNT_W + 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             ps2_clk;
  logic             ps2_data;
  logic [7:0]       key_data;
  logic [7:0]       key_ascii;
  logic [CNT_W-1:0] key_count;
  logic             key_down;
  logic             key_ext;
  logic             frame_err;

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_data  (key_data),
    .key_ascii (key_ascii),
    .key_count (key_count),
    .key_down  (key_down),
    .key_ext   (key_ext),
    .frame_err (frame_err)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [7:0] map_codes [37] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h29};
  string      map_chars = "abcdefghijklmnopqrstuvwxyz0123456789 ";
  logic [7:0] ascii_map [logic [7:0]];
  logic [7:0] extra_codes [4] = '{8'h05, 8'h76, 8'h5A, 8'h6B};

  bit         m_down, m_kext, m_brk, m_ext;
  logic [7:0] m_code;
  int         m_cnt;
  logic [SW-1:0] m_last;

  logic [SW-1:0] exp_q[$];
  int            exp_err = 0;

  function automatic logic [SW-1:0] model_snap();
    logic [7:0] a;
    a = 8'h00;
    if (m_down && !m_kext && ascii_map.exists(m_code)) a = ascii_map[m_code];
    return {m_code, a, CNT_W'(m_cnt), m_down, m_kext};
  endfunction

  task automatic model_reset();
    m_down = 0; m_kext = 0; m_brk = 0; m_ext = 0; m_code = 8'h00; m_cnt = 0;
    m_last = '0;
  endtask

  // Apply one received byte to the key state; queue the new visible state
  // when it differs from the last one.
  task automatic model_byte(input logic [7:0] b);
    logic [SW-1:0] s;
    bit same;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      same = m_down && (m_kext == m_ext) && (m_code == b);
      if (!m_brk) begin
        if (!same) begin
          m_down = 1; m_code = b; m_kext = m_ext;
          m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        end
      end else if (same) begin
        m_down = 0; m_code = 8'h00; m_kext = 0;
      end
      m_ext = 0; m_brk = 0;
    end
    s = model_snap();
    if (s != m_last) begin
      exp_q.push_back(s);
      m_last = s;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_bits({1'b1, ~^b, b, 1'b0}, 11);
    repeat (4) @(posedge clk);
  endtask

  task automatic send_bad_parity(input logic [7:0] b);
    exp_err++;
    send_bits({1'b1, ^b, b, 1'b0}, 11);
    repeat (4) @(posedge clk);
  endtask

  task automatic send_make(input logic [7:0] c, input bit e);
    if (e) send_byte(8'hE0);
    send_byte(c);
  endtask

  task automatic send_break(input logic [7:0] c, input bit e);
    if (e) send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(c);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  bit            mon_en = 1'b0;
  logic [SW-1:0] seen;
  logic [SW-1:0] cur;
  logic [SW-1:0] want;

  always @(negedge clk) begin
    if (mon_en) begin
      cur = {key_data, key_ascii, key_count, key_down, key_ext};
      if (cur !== seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_change: got %h with nothing expected", cur);
        end else begin
          want = exp_q.pop_front();
          if (cur !== want) begin
            errors++;
            $display("FAIL out_state: got %h expected %h", cur, want);
          end
        end
        seen = cur;
      end
      if (frame_err === 1'b1) begin
        checks++;
        if (exp_err > 0) exp_err--;
        else begin
          errors++;
          $display("FAIL frame_err: got 1 expected 0");
        end
      end
    end
  end

  // Cycle budget for the whole run.
  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] c;
    bit         e;
    for (int i = 0; i < 37; i++) ascii_map[map_codes[i]] = map_chars[i];
    model_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("reset_outputs", int'({key_data, key_ascii, key_count, key_down, key_ext, frame_err}), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    seen   = '0;
    mon_en = 1'b1;

    // Make and release 'a'.
    send_make(8'h1C, 0);
    send_break(8'h1C, 0);
    // Typematic repeat counts once.
    for (int i = 0; i < 5; i++) send_make(8'h1C, 0);
    send_break(8'h1C, 0);
    // Extended key; plain break must not release it.
    send_make(8'h75, 1);
    send_break(8'h75, 0);
    send_break(8'h75, 1);
    // Parity error, then the same code sent correctly.
    send_bad_parity(8'h16);
    send_make(8'h16, 0);
    send_break(8'h16, 0);
    // Stalled frame after five bits, then a good frame.
    exp_err++;
    send_bits({1'b1, ~^8'h24, 8'h24, 1'b0}, 5);
    repeat (TMO + 40) @(posedge clk);
    send_make(8'h24, 0);
    check_val("after_timeout_data", int'(key_data), 8'h24);
    send_break(8'h24, 0);

    // Random make/break/repeat/rollover traffic.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) c = extra_codes[$urandom_range(0, 3)];
      else c = map_codes[$urandom_range(0, 36)];
      e = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: send_make(c, e);
        1: send_break(m_code, m_kext);
        2: send_break(c, e);
        default: send_make(m_down ? m_code : c, m_down ? m_kext : e);
      endcase
    end

    // Reset in the middle of a frame.
    send_bits({1'b1, ~^8'h2C, 8'h2C, 1'b0}, 5);
    if (m_last != '0) exp_q.push_back('0);
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("midframe_reset", int'({key_data, key_ascii, key_count, key_down, key_ext}), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    send_make(8'h2C, 0);
    send_break(8'h2C, 0);

    // Count wrap: 255 more distinct presses by rollover returns to zero.
    for (int i = 0; i < 255; i++) send_make((i % 2 == 0) ? 8'h1C : 8'h32, 0);
    check_val("count_wrap", int'(key_count), 0);
    send_break(8'h32, 0);

    repeat (40) @(posedge clk);
    check_val("exp_queue_drained", exp_q.size(), 0);
    check_val("frame_err_all_seen", exp_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
